instruction_register: RTL and testbench

- 16-bit instruction register for the general-purpose calculator CPU.
- Captures an instruction word from the memory/data bus when write-enabled.
- Holds the word and continuously decodes it into the fixed instruction fields that the control unit and datapath consume: opcode, register select, branch address, immediate, and stack register select.

---
 rtl/instruction_register.sv | 32 +++
 tb/tb_instruction_register.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/instruction_register.sv
// 16-bit instruction register: captures the bus word on the falling clock edge when write-enabled
// and slices the held word into the overlapping opcode/address/immediate fields.
module instruction_register (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        w,
  output logic [15:0] out,
  output logic [5:0]  opcode,
  output logic        RA,
  output logic [9:0]  BA,
  output logic [8:0]  IMM,
  output logic [1:0]  RA_stack
);

  logic [15:0] r_ir_q;

  // Falling-edge capture lets the control unit set up w/in on the rising half of the cycle.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)   r_ir_q <= 16'h0000;
    else if (w) r_ir_q <= in;
  end

  // Fields deliberately overlap in [9:0]; the opcode decides which one is meaningful.
  assign out      = r_ir_q;
  assign opcode   = r_ir_q[15:10];
  assign RA       = r_ir_q[9];
  assign BA       = r_ir_q[9:0];
  assign IMM      = r_ir_q[8:0];
  assign RA_stack = r_ir_q[9:8];

endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard bench for instruction_register: stimulus queues hand-computed field sets,
// a separate monitor pops them and compares against the live DUT outputs.
module tb_instruction_register;

  logic        clk, rst, w;
  logic [15:0] in;
  logic [15:0] out;
  logic [5:0]  opcode;
  logic        RA;
  logic [9:0]  BA;
  logic [8:0]  IMM;
  logic [1:0]  RA_stack;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic [5:0]  opcode;
    logic        ra;
    logic [9:0]  ba;
    logic [8:0]  imm;
    logic [1:0]  ras;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  instruction_register dut (
    .clk(clk), .rst(rst), .in(in), .w(w),
    .out(out), .opcode(opcode), .RA(RA), .BA(BA), .IMM(IMM), .RA_stack(RA_stack)
  );

  task automatic fall();
    clk = 1'b0; #5;
  endtask

  task automatic rise();
    clk = 1'b1; #5;
  endtask

  task automatic expect_fields(input string nm, input logic [15:0] o, input logic [5:0] op,
                               input logic ra, input logic [9:0] ba, input logic [8:0] imm,
                               input logic [1:0] ras);
    exp_t e;
    e.name = nm; e.out = o; e.opcode = op; e.ra = ra; e.ba = ba; e.imm = imm; e.ras = ras;
    sb.push_back(e);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: each queued expectation is checked against the settled outputs.
  initial begin : monitor
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      chk({e.name, ".out"},      out,                e.out);
      chk({e.name, ".opcode"},   {10'd0, opcode},    {10'd0, e.opcode});
      chk({e.name, ".RA"},       {15'd0, RA},        {15'd0, e.ra});
      chk({e.name, ".BA"},       {6'd0, BA},         {6'd0, e.ba});
      chk({e.name, ".IMM"},      {7'd0, IMM},        {7'd0, e.imm});
      chk({e.name, ".RA_stack"}, {14'd0, RA_stack},  {14'd0, e.ras});
    end
  end

  initial begin : stim
    int spins;
    clk = 1'b1; rst = 1'b0; w = 1'b0; in = 16'b0110101010110011;
    #2;
    for (int i = 0; i < 3; i++) begin fall(); rise(); end
    expect_fields("reset", 16'h0000, 6'h00, 1'b0, 10'h000, 9'h000, 2'b00);

    // load 0x6AB3
    rst = 1'b1; w = 1'b1; #2;
    fall();
    expect_fields("load", 16'b0110101010110011, 6'b011010, 1'b1, 10'b1010110011,
                  9'b010110011, 2'b10);

    // hold with w=0 while in changes
    rise();
    w = 1'b0; in = 16'b0001011011110100; #2;
    fall();
    expect_fields("hold", 16'b0110101010110011, 6'b011010, 1'b1, 10'b1010110011,
                  9'b010110011, 2'b10);

    // rising edge alone must not load
    w = 1'b1; in = 16'hFFFF; #2;
    rise();
    expect_fields("rise_only", 16'b0110101010110011, 6'b011010, 1'b1, 10'b1010110011,
                  9'b010110011, 2'b10);
    fall();
    expect_fields("load_ffff", 16'hFFFF, 6'h3F, 1'b1, 10'h3FF, 9'h1FF, 2'b11);

    // async reset with clk static low
    rst = 1'b0; #1;
    expect_fields("async_rst", 16'h0000, 6'h00, 1'b0, 10'h000, 9'h000, 2'b00);

    // falling edge with w=1 during reset: reset wins
    in = 16'b1111110000000000; rise(); fall();
    expect_fields("rst_vs_load", 16'h0000, 6'h00, 1'b0, 10'h000, 9'h000, 2'b00);

    // release mid-cycle (clk low): nothing until next falling edge
    rst = 1'b1; #2;
    expect_fields("rel_mid", 16'h0000, 6'h00, 1'b0, 10'h000, 9'h000, 2'b00);
    rise();
    expect_fields("rel_rise", 16'h0000, 6'h00, 1'b0, 10'h000, 9'h000, 2'b00);
    fall();
    expect_fields("iso_fc00", 16'hFC00, 6'h3F, 1'b0, 10'h000, 9'h000, 2'b00);

    rise(); in = 16'h0100; #2; fall();
    expect_fields("iso_0100", 16'h0100, 6'h00, 1'b0, 10'h100, 9'h100, 2'b01);

    // RA set but RA_stack[0] clear; IMM drops bit 9
    rise(); in = 16'h0E00; #2; fall();
    expect_fields("iso_0e00", 16'h0E00, 6'h03, 1'b1, 10'h200, 9'h000, 2'b10);

    // w dropped: in toggles across several edges without effect
    w = 1'b0;
    for (int i = 0; i < 3; i++) begin rise(); in = 16'h1234 + 16'(i); #2; fall(); end
    expect_fields("hold_multi", 16'h0E00, 6'h03, 1'b1, 10'h200, 9'h000, 2'b10);

    spins = 0;
    while (sb.size() != 0 && spins < 100) begin #1; spins++; end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
